// File: rtl/score_tracker.sv
// Running-best Smith-Waterman score tracker fed by a pipelined max-reduction tree.
// Optional SCORE_POS_EN macro adds the step counter and reports the best score's step index.
module score_tracker #(
  parameter int DATA_WIDTH = 18,
  parameter int CNT_WIDTH  = 16,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step_valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] max_in,
  output logic                  max_init,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] score,
  output logic [CNT_WIDTH-1:0]  pos,
  output logic                  score_valid,
  input  logic                  score_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [PIPE_LAT-1:0]     tag_vld_q, tag_vld_d;
  logic [DATA_WIDTH-1:0]   best_q, best_d;
  logic [DATA_WIDTH-1:0]   max_clamped;
  logic                    push;
  logic                    fold_hit;

  // Tag valid bits travel alongside the tree's register layers.
  always_comb begin
    tag_vld_d[0] = push;
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    max_init = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          max_init = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (step_valid && last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave once the output stage holds the final tag, so DONE coincides with its fold.
        if (tag_vld_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (score_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push        = (state_q == S_RUN) && step_valid;
  assign max_clamped = max_in[DATA_WIDTH-1] ? '0 : max_in;
  assign fold_hit    = tag_vld_q[PIPE_LAT-1] && (max_clamped > best_q);

  always_comb begin
    best_d = best_q;
    if (max_init)      best_d = '0;
    else if (fold_hit) best_d = max_clamped;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tag_vld_q <= '0;
      best_q    <= '0;
    end else begin
      state_q   <= state_d;
      tag_vld_q <= tag_vld_d;
      best_q    <= best_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign score_valid = (state_q == S_DONE);
  assign score       = best_q;

`ifdef SCORE_POS_EN
  logic [CNT_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic [CNT_WIDTH-1:0] tag_idx_q [PIPE_LAT];
  logic [CNT_WIDTH-1:0] tag_idx_d [PIPE_LAT];

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (max_init)                        step_cnt_d = '0;
    else if (push && (step_cnt_q != '1)) step_cnt_d = step_cnt_q + CNT_WIDTH'(1);

    tag_idx_d[0] = push ? step_cnt_q : tag_idx_q[0];
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    pos_d = pos_q;
    if (max_init)      pos_d = '0;
    else if (fold_hit) pos_d = tag_idx_q[PIPE_LAT-1];
  end

  // NOTE: the index pipeline is reset as well; it is tiny and keeps X out of pos after an aborted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      pos_q      <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_idx_q[i] <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
      pos_q      <= pos_d;
      for (int i = 0; i < PIPE_LAT; i++) tag_idx_q[i] <= tag_idx_d[i];
    end
  end

  assign pos = pos_q;
`else
  assign pos = '0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed and randomized alignments
// checked against a max/argmax reference model.
module tb_score_tracker;

  localparam int DW  = 18;
  localparam int CW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, step_valid, last, score_ready;
  logic [DW-1:0] max_in;
  logic          max_init, busy, score_valid;
  logic [DW-1:0] score;
  logic [CW-1:0] pos;

  logic [DW-1:0] step_data;
  logic [DW-1:0] mi1, mi2;

  int n_checks = 0;
  int n_errors = 0;

  score_tracker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .PIPE_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .step_valid  (step_valid),
    .last        (last),
    .max_in      (max_in),
    .max_init    (max_init),
    .busy        (busy),
    .score       (score),
    .pos         (pos),
    .score_valid (score_valid),
    .score_ready (score_ready)
  );

  always #5 clk = ~clk;

  // Stand-in for the reduction tree: each step's value appears LAT cycles later;
  // cycles without a step carry a large positive value that must never be folded.
  always @(posedge clk) begin
    mi1 <= step_valid ? step_data : 18'h1FFFF;
    mi2 <= mi1;
  end
  assign max_in = mi2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Best = largest clamped value; position = first step reaching it (0 if best is 0).
  function automatic void model(input logic [DW-1:0] v[$], output logic [DW-1:0] s,
                                output logic [CW-1:0] p);
    logic [DW-1:0] c [$];
    s = '0;
    p = '0;
    foreach (v[i]) c.push_back(v[i][DW-1] ? '0 : v[i]);
    foreach (c[i]) if (c[i] > s) s = c[i];
    if (s != '0) begin
      for (int i = c.size() - 1; i >= 0; i--) if (c[i] == s) p = CW'(i);
    end
`ifndef SCORE_POS_EN
    p = '0;
`endif
  endfunction

  task automatic run(input logic [DW-1:0] vals[$], input bit gaps, input int hold,
                     input bit start_in_run, input bit start_on_accept, input bit abort);
    logic [DW-1:0] exp_s;
    logic [CW-1:0] exp_p;
    model(vals, exp_s, exp_p);

    start = 1'b1;
    @(negedge clk);
    check("max_init_pulse", 32'(max_init), 32'd1);
    check("busy_in_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;

    for (int i = 0; i < vals.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          step_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      step_valid = 1'b1;
      step_data  = vals[i];
      last       = (i == vals.size() - 1);
      start      = start_in_run && (i == 0);
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
      if (i == 0) begin
        check("score_cleared", 32'(score), 32'd0);
        check("max_init_low_run", 32'(max_init), 32'd0);
      end
      @(posedge clk); #1;
    end
    step_valid = 1'b0;
    last       = 1'b0;
    start      = 1'b0;

    if (abort) begin
      rst_n = 1'b0;
      #1;
      check("rst_max_init", 32'(max_init), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_score_valid", 32'(score_valid), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_pos", 32'(pos), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end

    repeat (LAT) begin
      @(negedge clk);
      check("sv_low_drain", 32'(score_valid), 32'd0);
      check("busy_drain", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("sv_done", 32'(score_valid), 32'd1);
    check("score_done", 32'(score), 32'(exp_s));
    check("pos_done", 32'(pos), 32'(exp_p));

    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("sv_hold", 32'(score_valid), 32'd1);
      check("score_hold", 32'(score), 32'(exp_s));
    end

    score_ready = 1'b1;
    start       = start_on_accept;
    #1;
    check("max_init_low_done", 32'(max_init), 32'd0);
    @(posedge clk); #1;
    score_ready = 1'b0;
    start       = 1'b0;
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd0);
    check("sv_after_accept", 32'(score_valid), 32'd0);
    check("score_kept_idle", 32'(score), 32'(exp_s));
    check("pos_kept_idle", 32'(pos), 32'(exp_p));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] q [$];
    logic [DW-1:0] held;

    rst_n = 1'b0; start = 1'b0; step_valid = 1'b0; last = 1'b0;
    score_ready = 1'b0; step_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_max_init", 32'(max_init), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sv", 32'(score_valid), 32'd0);
    check("reset_score", 32'(score), 32'd0);
    check("reset_pos", 32'(pos), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic run with a tie: the earlier 12 must win.
    q.delete();
    q.push_back(18'd5); q.push_back(18'd12); q.push_back(18'd7); q.push_back(18'd12);
    run(q, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Only negative maxima.
    q.delete();
    q.push_back(18'h3FFFF); q.push_back(18'h20000); q.push_back(18'h3FFFF);
    run(q, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Back-pressure in DONE with start arriving alongside score_ready, start in RUN.
    q.delete();
    q.push_back(18'd100); q.push_back(18'd3); q.push_back(18'd50);
    run(q, 1'b0, 5, 1'b1, 1'b1, 1'b0);

    // step_valid in IDLE must not create tags or change the held result.
    held = score;
    for (int i = 0; i < 4; i++) begin
      step_valid = 1'b1;
      step_data  = 18'h1F000;
      last       = (i == 3);
      @(posedge clk); #1;
    end
    step_valid = 1'b0;
    last       = 1'b0;
    repeat (LAT + 1) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_score", 32'(score), 32'(held));
      @(posedge clk); #1;
    end

    // Reset one cycle after last, then a clean run.
    q.delete();
    q.push_back(18'd900); q.push_back(18'd800); q.push_back(18'd700);
    run(q, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    q.delete();
    q.push_back(18'd10); q.push_back(18'd20); q.push_back(18'd20);
    run(q, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    // Randomized alignments with gaps between steps.
    for (int r = 0; r < 12; r++) begin
      q.delete();
      repeat ($urandom_range(1, 12)) begin
        if ($urandom_range(0, 3) == 0) q.push_back(DW'($urandom) | 18'h20000);
        else                           q.push_back(DW'($urandom_range(0, 40)));
      end
      run(q, 1'b1, $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
